// File: rtl/row_uram_arbiter_if.sv
// row_uram_arbiter_if: per-core request/lock handshake, gated URAM buses and the shared URAM port.
interface row_uram_arbiter_if #(
    parameter int NUM_CORES  = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CORES-1:0]            i_core_req;
    logic [NUM_CORES-1:0]            i_core_locked;
    logic [NUM_CORES-1:0]            o_core_grant;
    logic                            o_uram_emptied;
    logic [NUM_CORES-1:0]            i_core_uram_en;
    logic [NUM_CORES-1:0]            i_core_uram_wr_en;
    logic [NUM_CORES*ADDR_WIDTH-1:0] i_core_uram_addr;
    logic [NUM_CORES*DATA_WIDTH-1:0] i_core_uram_wr_data;
    logic                            o_uram_en;
    logic                            o_uram_wr_en;
    logic [ADDR_WIDTH-1:0]           o_uram_addr;
    logic [DATA_WIDTH-1:0]           o_uram_wr_data;
    logic                            i_uram_drained;
    logic                            i_drain_busy;

    modport slave (
        input  i_core_req, i_core_locked, i_core_uram_en, i_core_uram_wr_en,
               i_core_uram_addr, i_core_uram_wr_data, i_uram_drained, i_drain_busy,
        output o_core_grant, o_uram_emptied, o_uram_en, o_uram_wr_en, o_uram_addr, o_uram_wr_data
    );

    modport master (
        output i_core_req, i_core_locked, i_core_uram_en, i_core_uram_wr_en,
               i_core_uram_addr, i_core_uram_wr_data, i_uram_drained, i_drain_busy,
        input  o_core_grant, o_uram_emptied, o_uram_en, o_uram_wr_en, o_uram_addr, o_uram_wr_data
    );
endinterface

// File: rtl/row_uram_arbiter.sv
// row_uram_arbiter: round-robin URAM ownership arbiter with a registered URAM port mux.
// Optional grant timeout (GRANT without lock) is enabled by defining ROW_ARB_TIMEOUT_EN.
module row_uram_arbiter #(
    parameter int NUM_CORES     = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int GRANT_TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset,
    row_uram_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED, RELEASE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       ptr, owner, sel;
    logic [ADDR_WIDTH-1:0]  own_addr;
    logic [DATA_WIDTH-1:0]  own_data;

    if (NUM_CORES < 2 || NUM_CORES > 16 || GRANT_TIMEOUT < 1) begin : g_bad_param
        $error("row_uram_arbiter: parameter out of range");
    end

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        return IDX_W'(s >= NUM_CORES ? s - NUM_CORES : s);
    endfunction

    // Walk downward so the nearest requester above ptr is the last (winning) assignment.
    always_comb begin
        sel = ptr;
        for (int i = NUM_CORES; i >= 1; i--)
            sel = bus.i_core_req[wrap_add(ptr, i)] ? wrap_add(ptr, i) : sel;
    end

    always_comb begin
        own_addr = '0;
        own_data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            own_addr = (IDX_W'(k) == owner) ? bus.i_core_uram_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : own_addr;
            own_data = (IDX_W'(k) == owner) ? bus.i_core_uram_wr_data[k*DATA_WIDTH +: DATA_WIDTH] : own_data;
        end
    end

`ifdef ROW_ARB_TIMEOUT_EN
    logic [$clog2(GRANT_TIMEOUT+1)-1:0] tmo;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            ptr                <= IDX_W'(NUM_CORES - 1);
            owner              <= '0;
            bus.o_core_grant   <= '0;
            bus.o_uram_emptied <= 1'b0;
            bus.o_uram_en      <= 1'b0;
            bus.o_uram_wr_en   <= 1'b0;
            bus.o_uram_addr    <= '0;
            bus.o_uram_wr_data <= '0;
`ifdef ROW_ARB_TIMEOUT_EN
            tmo                <= '0;
`endif
        end else begin
            bus.o_uram_emptied <= bus.i_uram_drained;
            bus.o_uram_en      <= |bus.o_core_grant && bus.i_core_uram_en[owner];
            bus.o_uram_wr_en   <= |bus.o_core_grant && bus.i_core_uram_wr_en[owner];
            bus.o_uram_addr    <= |bus.o_core_grant ? own_addr : '0;
            bus.o_uram_wr_data <= |bus.o_core_grant ? own_data : '0;
            case (state)
                IDLE:
                    if (!bus.i_drain_busy && |bus.i_core_req) begin
                        bus.o_core_grant <= {{(NUM_CORES-1){1'b0}}, 1'b1} << sel;
                        owner            <= sel;
                        ptr              <= sel;
                        state            <= GRANT;
`ifdef ROW_ARB_TIMEOUT_EN
                        tmo              <= '0;
`endif
                    end
                GRANT:
                    if (bus.i_core_locked[owner]) begin
                        state <= LOCKED;
                    end else if (!bus.i_core_req[owner]) begin
                        state            <= RELEASE;
                        bus.o_core_grant <= '0;
`ifdef ROW_ARB_TIMEOUT_EN
                    end else if (int'(tmo) == GRANT_TIMEOUT - 1) begin
                        state            <= RELEASE;
                        bus.o_core_grant <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
`endif
                    end
                LOCKED:
                    if (!bus.i_core_locked[owner]) begin
                        state            <= RELEASE;
                        bus.o_core_grant <= '0;
                    end
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_uram_arbiter.sv
// tb_row_uram_arbiter: directed checks of grant sequencing, URAM mux, drain interlock, timeout and reset.
module tb_row_uram_arbiter;
    localparam int N  = 8;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    row_uram_arbiter_if #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    row_uram_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANT_TIMEOUT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int k, input logic en, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_core_uram_en[k]                  = en;
        bus.i_core_uram_wr_en[k]               = wr;
        bus.i_core_uram_addr[k*AW +: AW]       = a;
        bus.i_core_uram_wr_data[k*DW +: DW]    = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset                   = 1'b1;
        bus.i_core_req          = '0;
        bus.i_core_locked       = '0;
        bus.i_core_uram_en      = '0;
        bus.i_core_uram_wr_en   = '0;
        bus.i_core_uram_addr    = '0;
        bus.i_core_uram_wr_data = '0;
        bus.i_uram_drained      = 1'b0;
        bus.i_drain_busy        = 1'b0;
        tick(2);
        check("rst_grant", bus.o_core_grant, 0);
        check("rst_en", bus.o_uram_en, 0);
        check("rst_addr", bus.o_uram_addr, 0);
        check("rst_empt", bus.o_uram_emptied, 0);
        reset = 1'b0;
        tick();
        check("idle_grant", bus.o_core_grant, 0);

        // single requester: core 2
        bus.i_core_req = 8'h04;
        tick();
        check("single_grant", bus.o_core_grant, 8'h04);
        tick();
        check("single_hold", bus.o_core_grant, 8'h04);
        bus.i_core_locked = 8'h04;
        tick();
        bus.i_core_req = 8'h00;
        tick(3);
        check("single_locked", bus.o_core_grant, 8'h04);
        bus.i_core_locked = 8'h00;
        tick();
        check("single_release", bus.o_core_grant, 0);
        tick();
        check("single_idle", bus.o_core_grant, 0);

        // round robin from reset: 0..7 then 0, two low cycles between tenures
        pulse_reset();
        bus.i_core_req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            check($sformatf("rr_grant%0d", g), bus.o_core_grant, 64'(8'h01 << (g % 8)));
            bus.i_core_locked = 8'h01 << (g % 8);
            tick(3);
            bus.i_core_locked = 8'h00;
            tick();
            check($sformatf("rr_bubble%0d_a", g), bus.o_core_grant, 0);
            tick();
            check($sformatf("rr_bubble%0d_b", g), bus.o_core_grant, 0);
        end
        bus.i_core_req = 8'h00;

        // URAM mux: core 3 owner (ptr=0), core 5 drives unrelated traffic
        set_bus(3, 1'b1, 1'b1, 12'hABC, 32'hDEADBEEF);
        set_bus(5, 1'b1, 1'b0, 12'h555, 32'h12345678);
        bus.i_core_req = 8'h08;
        tick();
        check("mux_grant", bus.o_core_grant, 8'h08);
        check("mux_en_early", bus.o_uram_en, 0);
        tick();
        check("mux_en", bus.o_uram_en, 1);
        check("mux_wr", bus.o_uram_wr_en, 1);
        check("mux_addr", bus.o_uram_addr, 12'hABC);
        check("mux_data", bus.o_uram_wr_data, 32'hDEADBEEF);
        set_bus(3, 1'b1, 1'b0, 12'h123, 32'h0BADF00D);
        tick();
        check("mux_addr2", bus.o_uram_addr, 12'h123);
        check("mux_wr2", bus.o_uram_wr_en, 0);
        bus.i_core_req = 8'h00;
        tick();
        check("mux_withdraw", bus.o_core_grant, 0);
        check("mux_tail_addr", bus.o_uram_addr, 12'h123);
        tick();
        check("mux_off_en", bus.o_uram_en, 0);
        check("mux_off_addr", bus.o_uram_addr, 0);
        check("mux_off_data", bus.o_uram_wr_data, 0);
        set_bus(3, 1'b0, 1'b0, '0, '0);
        set_bus(5, 1'b0, 1'b0, '0, '0);

        // drain interlock and emptied re-timing
        bus.i_drain_busy = 1'b1;
        bus.i_core_req   = 8'h01;
        tick(3);
        check("busy_block", bus.o_core_grant, 0);
        bus.i_drain_busy = 1'b0;
        tick();
        check("busy_release", bus.o_core_grant, 8'h01);
        bus.i_drain_busy = 1'b1;
        tick();
        check("busy_keep", bus.o_core_grant, 8'h01);
        bus.i_uram_drained = 1'b1;
        check("empt_pre", bus.o_uram_emptied, 0);
        tick();
        check("empt_hi", bus.o_uram_emptied, 1);
        bus.i_uram_drained = 1'b0;
        tick();
        check("empt_lo", bus.o_uram_emptied, 0);
        bus.i_core_req   = 8'h00;
        bus.i_drain_busy = 1'b0;
        tick(3);

        // grant timeout: core 0 never locks
        pulse_reset();
        bus.i_core_req = 8'h03;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("tmo_hold%0d", c), bus.o_core_grant, 8'h01);
        end
`ifdef ROW_ARB_TIMEOUT_EN
        tick();
        check("tmo_revoke", bus.o_core_grant, 0);
        tick();
        check("tmo_idle", bus.o_core_grant, 0);
        tick();
        check("tmo_next", bus.o_core_grant, 8'h02);
`else
        tick(3);
        check("tmo_persist", bus.o_core_grant, 8'h01);
`endif
        bus.i_core_req = 8'h00;
        tick(3);

        // reset while core 4 is locked
        pulse_reset();
        bus.i_core_req = 8'h10;
        tick();
        check("rl_grant", bus.o_core_grant, 8'h10);
        bus.i_core_locked = 8'h10;
        set_bus(4, 1'b1, 1'b1, 12'h044, 32'hCAFE0004);
        bus.i_uram_drained = 1'b1;
        tick(2);
        check("rl_en", bus.o_uram_en, 1);
        check("rl_empt", bus.o_uram_emptied, 1);
        reset = 1'b1;
        tick();
        check("rl_rst_grant", bus.o_core_grant, 0);
        check("rl_rst_en", bus.o_uram_en, 0);
        check("rl_rst_addr", bus.o_uram_addr, 0);
        check("rl_rst_data", bus.o_uram_wr_data, 0);
        check("rl_rst_empt", bus.o_uram_emptied, 0);
        reset = 1'b0;
        bus.i_uram_drained = 1'b0;
        tick();
        check("rl_regrant", bus.o_core_grant, 8'h10);
        tick();
        check("rl_uram", bus.o_uram_addr, 12'h044);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
